// File: rtl/divider_pkg.sv
// Shared types and helpers for the iterative divider.
package divider_pkg;

  // Widest operand abs_mag can handle; callers zero-extend into this width.
  localparam int unsigned DIV_MAX_W  = 128;
  localparam int unsigned DIV_IDX_W  = $clog2(DIV_MAX_W);

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state_t;

  // Magnitude of a w-bit value held in the low bits of val. Only the low w
  // bits of the result are meaningful; -2^(w-1) maps to 2^(w-1) unsigned.
  function automatic logic [DIV_MAX_W-1:0] abs_mag(
    input logic [DIV_MAX_W-1:0] val,
    input int unsigned          w,
    input logic                 is_signed
  );
    logic [DIV_IDX_W-1:0] msb_idx;
    logic [DIV_MAX_W-1:0] res;
    msb_idx = DIV_IDX_W'(w - 1);
    if (is_signed && val[msb_idx]) begin
      res = ~val + DIV_MAX_W'(1);
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift, trial subtract, restore.
module div_restore_step #(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor_mag,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The stored partial remainder is always < divisor, so WIDTH bits hold it;
  // only the shifted value pr needs the extra bit.
  logic [WIDTH:0] pr;
  logic [WIDTH:0] diff;

  // Trial subtraction; a clear borrow bit means pr >= divisor_mag.
  always_comb begin
    pr   = {rem, quo[WIDTH-1]};
    diff = pr - {1'b0, divisor_mag};
    if (!diff[WIDTH]) begin
      rem_next = diff[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_next = pr[WIDTH-1:0];
      quo_next = {quo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring integer divider, truncating toward zero, with
// per-operand signedness and a valid/ready handshake on both sides.
module iterative_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic             dividend_sign,
  input  logic [WIDTH-1:0] divisor,
  input  logic             divisor_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dmag_q, dmag_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q, dbz_d;

  logic [DIV_MAX_W-1:0] dividend_ext, divisor_ext;
  logic [WIDTH-1:0]     dividend_mag, divisor_mag;
  logic                 neg_n, neg_d;
  logic                 zero_div, ovf_div;
  logic [WIDTH-1:0]     step_rem, step_quo;

  div_restore_step #(.WIDTH(WIDTH)) u_step (
    .rem         (rem_q),
    .quo         (quo_q),
    .divisor_mag (dmag_q),
    .rem_next    (step_rem),
    .quo_next    (step_quo)
  );

  // Operand decode for the accept edge: signs, magnitudes, special cases.
  always_comb begin
    dividend_ext               = '0;
    divisor_ext                = '0;
    dividend_ext[WIDTH-1:0]    = dividend;
    divisor_ext[WIDTH-1:0]     = divisor;
    dividend_mag = WIDTH'(abs_mag(dividend_ext, WIDTH, dividend_sign));
    divisor_mag  = WIDTH'(abs_mag(divisor_ext, WIDTH, divisor_sign));
    neg_n        = dividend_sign & dividend[WIDTH-1];
    neg_d        = divisor_sign & divisor[WIDTH-1];
    zero_div     = (divisor == '0);
    // Most-negative / -1 would overflow the signed quotient; answer it directly.
    ovf_div      = dividend_sign & divisor_sign & (dividend == MIN_NEG) & (&divisor);
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= DIV_IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dmag_q      <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      out_valid_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dmag_q      <= dmag_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      out_valid_q <= out_valid_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  // Next-state selection.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DIV_IDLE: if (in_valid) state_d = (zero_div || ovf_div) ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (cnt_q == '0) state_d = DIV_FIX;
      DIV_FIX:  state_d = DIV_DONE;
      DIV_DONE: if (out_ready) state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
  end

  // Work-register and result updates for each state.
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dmag_d      = dmag_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    out_valid_d = out_valid_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    case (state_q)
      DIV_IDLE: begin
        if (in_valid) begin
          rem_d   = '0;
          quo_d   = dividend_mag;
          dmag_d  = divisor_mag;
          q_neg_d = neg_n ^ neg_d;
          r_neg_d = neg_n;
          cnt_d   = CNT_W'(WIDTH - 1);
          if (zero_div) begin
            quotient_d  = '1;
            remainder_d = dividend;
            dbz_d       = 1'b1;
            out_valid_d = 1'b1;
          end else if (ovf_div) begin
            quotient_d  = dividend;
            remainder_d = '0;
            dbz_d       = 1'b0;
            out_valid_d = 1'b1;
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
      end
      DIV_FIX: begin
        quotient_d  = q_neg_q ? -quo_q : quo_q;
        remainder_d = r_neg_q ? -rem_q : rem_q;
        dbz_d       = 1'b0;
        out_valid_d = 1'b1;
      end
      DIV_DONE: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  // Handshake and result outputs.
  always_comb begin
    in_ready    = (state_q == DIV_IDLE);
    out_valid   = out_valid_q;
    quotient    = quotient_q;
    remainder   = remainder_q;
    div_by_zero = dbz_q;
  end

endmodule
